// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared core definitions: interrupt ID width and interrupt-source FSM states
package riscv_defines;

    localparam int IRQ_ID_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } irq_src_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// rtl/riscv_irq_prio_enc.sv - combinational priority encoder, highest set index wins
module riscv_irq_prio_enc #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 6
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/riscv_irq_source.sv
// rtl/riscv_irq_source.sv - edge-captured interrupt source and arbiter feeding the core IRQ interface
// Optional input synchroniser: RISCV_IRQ_SYNC_EN
module riscv_irq_source #(
    parameter int NUM_IRQ  = 32,
    parameter int IRQ_ID_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_lines_i,
    input  logic [NUM_IRQ-1:0]  irq_enable_i,
    input  logic [NUM_IRQ-1:0]  irq_sec_cfg_i,
    input  logic [NUM_IRQ-1:0]  irq_clear_i,
    output logic                irq_pending_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic                irq_sec_o,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
    output logic [NUM_IRQ-1:0]  pending_o,
    output logic                ack_err_o
);

    import riscv_defines::*;

    logic [NUM_IRQ-1:0] lines_s;
    logic [NUM_IRQ-1:0] line_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ack_hit;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] cand;
    logic               cand_valid;
    logic [IRQ_ID_W-1:0] win_idx;
    logic               win_sec;
    logic               ack_bad;
    logic               ack_err_q;
    logic               is_req;
    irq_src_state_e     state_q;

`ifdef RISCV_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_lines_i;
            sync2_q <= sync1_q;
        end
    end

    assign lines_s = sync2_q;
`else
    assign lines_s = irq_lines_i;
`endif

    // Out-of-range ack IDs decode to no bit, so they can only raise the error.
    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_hit[i] = irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(i));
        end
    end

    assign rise    = lines_s & ~line_q;
    assign clr     = irq_clear_i | ack_hit;
    assign pend_d  = rise | (pend_q & ~clr);
    assign ack_bad = irq_ack_i & ~(|(pend_q & ack_hit));
    assign cand    = pend_q & irq_enable_i;

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (IRQ_ID_W)
    ) u_prio_enc (
        .req_i   (cand),
        .valid_o (cand_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        win_sec = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (win_idx == IRQ_ID_W'(i)) begin
                win_sec = irq_sec_cfg_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q    <= '0;
            pend_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            line_q    <= lines_s;
            pend_q    <= pend_d;
            ack_err_q <= ack_err_q | ack_bad;
        end
    end

    // ACKED is a forced one-cycle gap so the core never re-samples a stale request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cand_valid) state_q <= REQ;
                REQ: begin
                    if (irq_ack_i)        state_q <= ACKED;
                    else if (!cand_valid) state_q <= IDLE;
                end
                ACKED:   state_q <= cand_valid ? REQ : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign is_req        = (state_q == REQ);
    assign irq_pending_o = is_req;
    assign irq_id_o      = is_req ? win_idx : '0;
    assign irq_sec_o     = is_req & win_sec;
    assign pending_o     = pend_q;
    assign ack_err_o     = ack_err_q;

endmodule

// File: tb/tb_riscv_irq_source.sv
// tb/tb_riscv_irq_source.sv - directed self-checking bench for riscv_irq_source
module tb_riscv_irq_source;

    localparam int NUM_IRQ  = 32;
    localparam int IRQ_ID_W = 6;

    logic                clk;
    logic                rst;
    logic [NUM_IRQ-1:0]  lines;
    logic [NUM_IRQ-1:0]  en;
    logic [NUM_IRQ-1:0]  sec;
    logic [NUM_IRQ-1:0]  clr;
    logic                irq_pending;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                irq_sec;
    logic                ack;
    logic [IRQ_ID_W-1:0] ack_id;
    logic [NUM_IRQ-1:0]  pending;
    logic                ack_err;

    int n_checks;
    int n_errors;

    riscv_irq_source #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_ID_W (IRQ_ID_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_lines_i   (lines),
        .irq_enable_i  (en),
        .irq_sec_cfg_i (sec),
        .irq_clear_i   (clr),
        .irq_pending_o (irq_pending),
        .irq_id_o      (irq_id),
        .irq_sec_o     (irq_sec),
        .irq_ack_i     (ack),
        .irq_ack_id_i  (ack_id),
        .pending_o     (pending),
        .ack_err_o     (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input int idx);
        lines[idx] = 1'b1;
        step();
        lines = '0;
    endtask

    task automatic do_ack(input int id);
        ack    = 1'b1;
        ack_id = IRQ_ID_W'(id);
        step();
        ack    = 1'b0;
        ack_id = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(irq_pending), 64'd0);
        check({tag, "_id"},  64'(irq_id),      64'd0);
        check({tag, "_sec"}, 64'(irq_sec),     64'd0);
        check({tag, "_pend"}, 64'(pending),    64'd0);
        check({tag, "_err"}, 64'(ack_err),     64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        lines  = '0;
        en     = '1;
        sec    = 32'h0000_0020;
        clr    = '0;
        ack    = 1'b0;
        ack_id = '0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Single line 5: request two cycles after the edge, one-cycle gap after ack.
        pulse_line(5);
        check("l5_pend_set", 64'(pending), 64'h20);
        check("l5_req_early", 64'(irq_pending), 64'd0);
        step();
        check("l5_req", 64'(irq_pending), 64'd1);
        check("l5_id", 64'(irq_id), 64'd5);
        check("l5_sec", 64'(irq_sec), 64'd1);
        do_ack(5);
        check("l5_acked_req", 64'(irq_pending), 64'd0);
        check("l5_acked_pend", 64'(pending), 64'd0);
        step();
        check("l5_idle_req", 64'(irq_pending), 64'd0);

        // Lines 3 and 20 together: 20 first, 3 offered at a+2.
        lines = (32'd1 << 3) | (32'd1 << 20);
        step();
        lines = '0;
        step();
        check("l3_20_id", 64'(irq_id), 64'd20);
        check("l3_20_sec", 64'(irq_sec), 64'd0);
        do_ack(20);
        check("l3_20_gap", 64'(irq_pending), 64'd0);
        step();
        check("l3_reoffer_req", 64'(irq_pending), 64'd1);
        check("l3_reoffer_id", 64'(irq_id), 64'd3);
        do_ack(3);
        step();

        // Line 9 overtakes line 7 while in REQ.
        pulse_line(7);
        step();
        check("l7_id", 64'(irq_id), 64'd7);
        pulse_line(9);
        check("l9_switch_id", 64'(irq_id), 64'd9);
        do_ack(9);
        check("l7_left_pend", 64'(pending), 64'h80);
        check("l7_gap", 64'(irq_pending), 64'd0);
        step();
        check("l7_reoffer_req", 64'(irq_pending), 64'd1);
        check("l7_reoffer_id", 64'(irq_id), 64'd7);
        do_ack(7);
        step();

        // New edge on line 4 in the ack cycle: set beats clear.
        pulse_line(4);
        step();
        check("l4_id", 64'(irq_id), 64'd4);
        lines[4] = 1'b1;
        do_ack(4);
        lines = '0;
        check("l4_kept_pend", 64'(pending), 64'h10);
        check("l4_gap", 64'(irq_pending), 64'd0);
        step();
        check("l4_rereq_req", 64'(irq_pending), 64'd1);
        check("l4_rereq_id", 64'(irq_id), 64'd4);
        do_ack(4);
        step();
        check("l4_no_err", 64'(ack_err), 64'd0);
        check("l4_clean", 64'(pending), 64'd0);

        // Software clear removes a pending bit.
        pulse_line(8);
        clr[8] = 1'b1;
        step();
        clr = '0;
        check("clr_pend", 64'(pending), 64'd0);
        step();
        check("clr_req", 64'(irq_pending), 64'd0);

        // Out-of-range ack ID 40 with a masked pending bit 2.
        en[2] = 1'b0;
        pulse_line(2);
        step();
        check("masked_no_req", 64'(irq_pending), 64'd0);
        do_ack(40);
        check("ack40_err", 64'(ack_err), 64'd1);
        check("ack40_pend", 64'(pending), 64'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_reset", 64'(ack_err), 64'd0);

        // Ack of a clear bit (12) is an error and leaves pending alone; sticky.
        pulse_line(2);
        step();
        do_ack(12);
        check("ack12_err", 64'(ack_err), 64'd1);
        check("ack12_pend", 64'(pending), 64'h4);
        step();
        step();
        check("ack12_sticky", 64'(ack_err), 64'd1);
        do_ack(2);
        check("idle_ack_clears", 64'(pending), 64'd0);
        en = '1;

        // Dropping enable[6] in REQ withdraws the request, bit stays pending.
        pulse_line(6);
        step();
        check("l6_req", 64'(irq_pending), 64'd1);
        en[6] = 1'b0;
        step();
        check("l6_withdrawn", 64'(irq_pending), 64'd0);
        check("l6_still_pend", 64'(pending), 64'h40);
        en = '1;
        step();
        check("l6_reoffer_id", 64'(irq_id), 64'd6);

        // Reset in REQ clears everything on the next edge.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
